mux4_rr_arbiter: RTL and testbench

- Round-robin arbiter sharing one 4:1 single-bit mux among four requesters (A=0, B=1, C=2, D=3).
- Drives the mux select lines S1/S0 plus a one-hot grant and a valid flag.
- Each owner holds the mux until it drops its request.
- Sits directly in front of Mux4x1; S1/S0 connect straight to its select inputs.

---
 rtl/mux4_rr_arbiter.sv | 120 ++++++++++++
 tb/tb_mux4_rr_arbiter.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/mux4_rr_arbiter.sv
// Round-robin owner arbiter for a shared 4:1 mux: registered one-hot grant, select lines and hold counter.
// Optional macro HOLD_LIMIT_EN forces a release after MAX_HOLD consecutive cycles of ownership.
module mux4_rr_arbiter #(
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    output logic [3:0] grant,
    output logic       valid,
    output logic       S1,
    output logic       S0,
    output logic [7:0] hold_cnt
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;

    logic [0:0] state_q, state_d;
    logic [1:0] owner_q, owner_d;
    logic [1:0] last_q,  last_d;
    logic [3:0] grant_q, grant_d;
    logic [7:0] hold_q,  hold_d;

    logic [2:0] pick_idle;
    logic [2:0] pick_rel;
    logic       limit_hit;
    logic       release_now;

    if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
        $error("mux4_rr_arbiter: MAX_HOLD must lie in 2..255");
    end

    // Returns {found, index}; search order is base+1, base+2, base+3 and finally base itself.
    function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] base);
        logic [2:0] res;
        logic [1:0] idx;
        res = '0;
        for (int unsigned k = 1; k <= 4; k++) begin
            idx = 2'(32'(base) + k);
            if (!res[2] && r[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

`ifdef HOLD_LIMIT_EN
    assign limit_hit = (hold_q == 8'(MAX_HOLD));
`else
    assign limit_hit = 1'b0;
`endif

    assign pick_idle   = rr_pick(req, last_q);
    assign pick_rel    = rr_pick(req, owner_q);
    assign release_now = !req[owner_q] || limit_hit;

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        grant_d = grant_q;
        hold_d  = hold_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_idle[2]) begin
                    state_d = ST_GRANT;
                    owner_d = pick_idle[1:0];
                    grant_d = 4'b0001 << pick_idle[1:0];
                    hold_d  = 8'd1;
                end
            end
            ST_GRANT: begin
                if (release_now) begin
                    // A forced release finds the still-requesting owner only as the last candidate.
                    last_d = owner_q;
                    if (pick_rel[2]) begin
                        owner_d = pick_rel[1:0];
                        grant_d = 4'b0001 << pick_rel[1:0];
                        hold_d  = 8'd1;
                    end else begin
                        state_d = ST_IDLE;
                        grant_d = '0;
                        hold_d  = '0;
                    end
                end else if (hold_q != 8'hFF) begin
                    hold_d = hold_q + 8'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
                hold_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            owner_q <= '0;
            last_q  <= 2'd3;
            grant_q <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            grant_q <= grant_d;
            hold_q  <= hold_d;
        end
    end

    assign grant    = grant_q;
    assign valid    = |grant_q;
    assign S1       = owner_q[1];
    assign S0       = owner_q[0];
    assign hold_cnt = hold_q;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed self-checking bench for mux4_rr_arbiter with hand-computed expectations.
module tb_mux4_rr_arbiter;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [3:0] grant;
    logic       valid;
    logic       S1;
    logic       S0;
    logic [7:0] hold_cnt;

    int unsigned n_cmp;
    int unsigned n_bad;

    mux4_rr_arbiter #(.MAX_HOLD(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .grant    (grant),
        .valid    (valid),
        .S1       (S1),
        .S0       (S0),
        .hold_cnt (hold_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [3:0] eg, input logic [1:0] es, input logic [7:0] eh);
        chk({tag, ".grant"}, {4'b0, grant}, {4'b0, eg});
        chk({tag, ".valid"}, {7'b0, valid}, {7'b0, |eg});
        chk({tag, ".sel"},   {6'b0, S1, S0}, {6'b0, es});
        chk({tag, ".hold"},  hold_cnt, eh);
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst   = 1'b1;
        req   = 4'b1111;

        // reset held with all requests pending
        step(); chk_all("rst1", 4'b0000, 2'b00, 8'd0);
        step(); chk_all("rst2", 4'b0000, 2'b00, 8'd0);
        rst = 1'b0;
        step(); chk_all("rr_a1", 4'b0001, 2'b00, 8'd1);

        // rotation: each owner drops its bit after two cycles
        step(); chk_all("rr_a2", 4'b0001, 2'b00, 8'd2);
        req = 4'b1110;
        step(); chk_all("rr_b1", 4'b0010, 2'b01, 8'd1);
        req = 4'b1111;
        step(); chk_all("rr_b2", 4'b0010, 2'b01, 8'd2);
        req = 4'b1101;
        step(); chk_all("rr_c1", 4'b0100, 2'b10, 8'd1);
        req = 4'b1111;
        step(); chk_all("rr_c2", 4'b0100, 2'b10, 8'd2);
        req = 4'b1011;
        step(); chk_all("rr_d1", 4'b1000, 2'b11, 8'd1);
        req = 4'b1111;
        step(); chk_all("rr_d2", 4'b1000, 2'b11, 8'd2);
        req = 4'b0111;
        step(); chk_all("rr_a_again", 4'b0001, 2'b00, 8'd1);
        req = 4'b0000;
        step(); chk_all("rr_idle", 4'b0000, 2'b00, 8'd0);

        // single requester C; select lines keep value when idle
        req = 4'b0100;
        step(); chk_all("single1", 4'b0100, 2'b10, 8'd1);
        step(); chk_all("single2", 4'b0100, 2'b10, 8'd2);
        step(); chk_all("single3", 4'b0100, 2'b10, 8'd3);
        req = 4'b0000;
        step(); chk_all("single_idle", 4'b0000, 2'b10, 8'd0);

        // wrap after D, then skip B
        req = 4'b1000;
        step(); chk_all("wrap_d", 4'b1000, 2'b11, 8'd1);
        req = 4'b0000;
        step(); chk_all("wrap_idle", 4'b0000, 2'b11, 8'd0);
        req = 4'b0101;
        step(); chk_all("wrap_a", 4'b0001, 2'b00, 8'd1);
        req = 4'b0100;
        step(); chk_all("skip_c", 4'b0100, 2'b10, 8'd1);
        req = 4'b0000;
        step(); chk_all("skip_idle", 4'b0000, 2'b10, 8'd0);

        // reset in the middle of a tenure
        req = 4'b0010;
        step(); chk_all("mid_b1", 4'b0010, 2'b01, 8'd1);
        step(); step(); step();
        chk_all("mid_b4", 4'b0010, 2'b01, 8'd4);
        rst = 1'b1;
        step(); chk_all("mid_rst", 4'b0000, 2'b00, 8'd0);
        rst = 1'b0;
        step(); chk_all("mid_b_regrant", 4'b0010, 2'b01, 8'd1);

        // non-owner toggling is ignored until B releases; D wins over A from pointer B
        req = 4'b0110;
        step(); chk_all("toggle1", 4'b0010, 2'b01, 8'd2);
        req = 4'b1010;
        step(); chk_all("toggle2", 4'b0010, 2'b01, 8'd3);
        req = 4'b1001;
        step(); chk_all("toggle_d", 4'b1000, 2'b11, 8'd1);
        req = 4'b1000;

`ifndef HOLD_LIMIT_EN
        // unlimited hold: counter saturates
        for (int i = 0; i < 253; i++) step();
        chk_all("sat254", 4'b1000, 2'b11, 8'd254);
        step(); chk_all("sat255", 4'b1000, 2'b11, 8'd255);
        step(); chk_all("sat_hold", 4'b1000, 2'b11, 8'd255);
        req = 4'b0001;
        step(); chk_all("sat_release", 4'b0001, 2'b00, 8'd1);
`else
        // hold limit of 4: sole requester re-granted without a gap
        step(); chk_all("lim_d2", 4'b1000, 2'b11, 8'd2);
        step(); chk_all("lim_d3", 4'b1000, 2'b11, 8'd3);
        step(); chk_all("lim_d4", 4'b1000, 2'b11, 8'd4);
        step(); chk_all("lim_d_regrant", 4'b1000, 2'b11, 8'd1);
        req = 4'b0011;
        for (int i = 0; i < 12; i++) begin
            step();
            if (((i / 4) % 2) == 0) chk_all("lim_alt_a", 4'b0001, 2'b00, 8'((i % 4) + 1));
            else                    chk_all("lim_alt_b", 4'b0010, 2'b01, 8'((i % 4) + 1));
        end
        req = 4'b0000;
        step(); chk_all("lim_idle", 4'b0000, 2'b00, 8'd0);
        req = 4'b0001;
        for (int i = 0; i < 8; i++) begin
            step();
            chk_all("lim_solo", 4'b0001, 2'b00, 8'((i % 4) + 1));
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
